// File: rtl/dmem_port_arb.sv
// Two-requester arbiter in front of a synchronous single-port data RAM.
// Define DMEM_ARB_RR_EN for round-robin conflict resolution; default is fixed priority to m0.
module dmem_port_arb #(
   parameter int unsigned AW = 15,
   parameter int unsigned DW = 32,
   parameter int unsigned CW = 16
) (
   input  logic            clk_i,
   input  logic            reset_ni,
   input  logic            m0_valid_i,
   output logic            m0_ready_o,
   input  logic [AW-1:0]   m0_addr_i,
   input  logic [DW/8-1:0] m0_be_i,
   input  logic [DW-1:0]   m0_wdata_i,
   input  logic            m0_we_i,
   output logic            m0_rvalid_o,
   input  logic            m1_valid_i,
   output logic            m1_ready_o,
   input  logic [AW-1:0]   m1_addr_i,
   input  logic [DW/8-1:0] m1_be_i,
   input  logic [DW-1:0]   m1_wdata_i,
   input  logic            m1_we_i,
   output logic            m1_rvalid_o,
   output logic [DW-1:0]   rdata_o,
   output logic [AW-1:0]   address_o,
   output logic [DW/8-1:0] byteena_o,
   output logic [DW-1:0]   data_o,
   output logic            enable_o,
   output logic            wren_o,
   input  logic [DW-1:0]   q_i,
   output logic [CW-1:0]   conflict_cnt_o
);

   logic          gnt0, gnt1, conflict, pick0;
   logic          last_q, last_d;
   logic          rsp_vld_q, rsp_vld_d;
   logic          rsp_id_q, rsp_id_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      conflict = m0_valid_i & m1_valid_i;
`ifdef DMEM_ARB_RR_EN
      // last_q == 1 means m1 won last time, so m0 is next in turn
      pick0 = last_q;
`else
      pick0 = 1'b1;
`endif
      gnt0 = reset_ni & m0_valid_i & (~m1_valid_i | pick0);
      gnt1 = reset_ni & m1_valid_i & ~gnt0;

      m0_ready_o = gnt0;
      m1_ready_o = gnt1;
      enable_o   = gnt0 | gnt1;
      wren_o     = gnt1 ? m1_we_i : (gnt0 & m0_we_i);
      address_o  = gnt1 ? m1_addr_i  : m0_addr_i;
      byteena_o  = gnt1 ? m1_be_i    : m0_be_i;
      data_o     = gnt1 ? m1_wdata_i : m0_wdata_i;

      last_d    = enable_o ? gnt1 : last_q;
      rsp_vld_d = enable_o;
      rsp_id_d  = gnt1;
      cnt_d     = (conflict && (cnt_q != {CW{1'b1}})) ? cnt_q + CW'(1) : cnt_q;
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         last_q    <= 1'b1;
         rsp_vld_q <= 1'b0;
         rsp_id_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         last_q    <= last_d;
         rsp_vld_q <= rsp_vld_d;
         rsp_id_q  <= rsp_id_d;
         cnt_q     <= cnt_d;
      end
   end

   assign m0_rvalid_o    = rsp_vld_q & ~rsp_id_q;
   assign m1_rvalid_o    = rsp_vld_q & rsp_id_q;
   assign rdata_o        = q_i;
   assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_dmem_port_arb.sv
// Self-checking bench for dmem_port_arb: directed scenarios then randomized traffic,
// checked against a transaction-level model with a behavioural RAM attached to the DUT.
module tb_dmem_port_arb;

`ifdef DMEM_ARB_RR_EN
   localparam bit RrEn = 1'b1;
`else
   localparam bit RrEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_ni;
   logic        v    [2];
   logic [14:0] a    [2];
   logic [3:0]  be   [2];
   logic [31:0] wd   [2];
   logic        we   [2];

   logic        m0_ready, m1_ready, m0_rvalid, m1_rvalid, enable, wren;
   logic [31:0] rdata, data, q;
   logic [14:0] address;
   logic [3:0]  byteena;
   logic [15:0] cnt;
   logic        s_m0_ready, s_m1_ready, s_m0_rvalid, s_m1_rvalid, s_enable, s_wren;
   logic [31:0] s_rdata, s_data;
   logic [14:0] s_address;
   logic [3:0]  s_byteena;
   logic [1:0]  cnt2;

   always #5 clk = ~clk;

   dmem_port_arb u_dut (
      .clk_i(clk), .reset_ni(reset_ni),
      .m0_valid_i(v[0]), .m0_ready_o(m0_ready), .m0_addr_i(a[0]), .m0_be_i(be[0]),
      .m0_wdata_i(wd[0]), .m0_we_i(we[0]), .m0_rvalid_o(m0_rvalid),
      .m1_valid_i(v[1]), .m1_ready_o(m1_ready), .m1_addr_i(a[1]), .m1_be_i(be[1]),
      .m1_wdata_i(wd[1]), .m1_we_i(we[1]), .m1_rvalid_o(m1_rvalid),
      .rdata_o(rdata), .address_o(address), .byteena_o(byteena), .data_o(data),
      .enable_o(enable), .wren_o(wren), .q_i(q), .conflict_cnt_o(cnt)
   );

   dmem_port_arb #(.CW(2)) u_sat (
      .clk_i(clk), .reset_ni(reset_ni),
      .m0_valid_i(v[0]), .m0_ready_o(s_m0_ready), .m0_addr_i(a[0]), .m0_be_i(be[0]),
      .m0_wdata_i(wd[0]), .m0_we_i(we[0]), .m0_rvalid_o(s_m0_rvalid),
      .m1_valid_i(v[1]), .m1_ready_o(s_m1_ready), .m1_addr_i(a[1]), .m1_be_i(be[1]),
      .m1_wdata_i(wd[1]), .m1_we_i(we[1]), .m1_rvalid_o(s_m1_rvalid),
      .rdata_o(s_rdata), .address_o(s_address), .byteena_o(s_byteena), .data_o(s_data),
      .enable_o(s_enable), .wren_o(s_wren), .q_i(q), .conflict_cnt_o(cnt2)
   );

   // Behavioural RAM driven by the DUT's RAM port
   logic [31:0] ram [32768];
   always @(posedge clk) begin
      if (enable) begin
         if (wren) begin
            for (int b = 0; b < 4; b++) if (byteena[b]) ram[address][8*b +: 8] <= data[8*b +: 8];
         end else begin
            q <= ram[address];
         end
      end
   end

   // Reference model state
   logic [31:0] shadow [32768];
   int          m_last, m_cnt, m_cnt2;
   bit          m_pend, m_id, m_rd;
   logic [31:0] m_rdata;
   int          n_vec, n_err;
   logic [3:0]  pat;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pend = 0; m_last = 1; m_cnt = 0; m_cnt2 = 0;
   endtask

   task automatic set_req(input int x, input bit vv, input logic [14:0] aa, input logic [3:0] bb,
                          input logic [31:0] dd, input bit ww);
      v[x] = vv; a[x] = aa; be[x] = bb; wd[x] = dd; we[x] = ww;
   endtask

   task automatic idle();
      set_req(0, 0, '0, '0, '0, 0);
      set_req(1, 0, '0, '0, '0, 0);
   endtask

   // One clock cycle: called just after a rising edge with inputs already applied
   task automatic cycle();
      int g;
      if (!reset_ni || (!v[0] && !v[1])) g = -1;
      else if (v[0] && v[1]) g = (RrEn && m_last == 0) ? 1 : 0;
      else g = v[0] ? 0 : 1;
      @(negedge clk);
      check("m0_ready", 32'(m0_ready), 32'(g == 0));
      check("m1_ready", 32'(m1_ready), 32'(g == 1));
      check("enable", 32'(enable), 32'(g >= 0));
      check("wren", 32'(wren), (g >= 0) ? 32'(we[g]) : 32'd0);
      if (g >= 0) begin
         check("address", 32'(address), 32'(a[g]));
         check("byteena", 32'(byteena), 32'(be[g]));
         check("data", data, wd[g]);
      end
      check("m0_rvalid", 32'(m0_rvalid), 32'(m_pend && !m_id));
      check("m1_rvalid", 32'(m1_rvalid), 32'(m_pend && m_id));
      if (m_pend && m_rd) check("rdata", rdata, m_rdata);
      check("conflict_cnt", 32'(cnt), 32'(m_cnt));
      check("conflict_cnt_sat", 32'(cnt2), 32'(m_cnt2));
      pat = {pat[2:0], m0_ready};
      @(posedge clk);
      #1;
      if (!reset_ni) begin
         model_reset();
      end else begin
         if (v[0] && v[1]) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
         end
         m_pend = (g >= 0);
         if (g >= 0) begin
            m_id    = (g == 1);
            m_rd    = !we[g];
            m_rdata = shadow[a[g]];
            if (we[g])
               for (int b = 0; b < 4; b++) if (be[g][b]) shadow[a[g]][8*b +: 8] = wd[g][8*b +: 8];
            m_last = g;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) begin
         ram[i]    = (i * 32'h9E3779B9) ^ 32'h5A5A5A5A;
         shadow[i] = (i * 32'h9E3779B9) ^ 32'h5A5A5A5A;
      end
      ram[16] = 32'hDEADBEEF; shadow[16] = 32'hDEADBEEF;
      ram[32] = 32'h11223344; shadow[32] = 32'h11223344;
   end

   initial begin
      n_vec = 0; n_err = 0; pat = '0;
      model_reset();
      reset_ni = 1'b0;
      idle();
      @(posedge clk); #1;
      // Reset state, including valids held high: nothing may be granted
      set_req(0, 1, 15'h1, 4'hF, 32'h1, 0);
      set_req(1, 1, 15'h2, 4'hF, 32'h2, 1);
      cycle();
      idle();
      cycle();
      reset_ni = 1'b1;

      // Single read of 0x0010
      set_req(0, 1, 15'h0010, 4'hF, 32'h0, 0);
      cycle();
      idle();
      cycle();
      check("single_read", rdata, 32'hDEADBEEF);

      // Byte write then read of 0x0020 by m1
      set_req(1, 1, 15'h0020, 4'b0001, 32'h000000AA, 1);
      cycle();
      set_req(1, 1, 15'h0020, 4'hF, 32'h0, 0);
      cycle();
      idle();
      cycle();
      check("byte_write_read", rdata, 32'h112233AA);

      // Conflict for 4 cycles from fresh reset, then a fifth to saturate CW=2
      reset_ni = 1'b0;
      model_reset();
      cycle();
      reset_ni = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_req(0, 1, 15'(100 + i), 4'hF, 32'h0, 0);
         set_req(1, 1, 15'(200 + i), 4'hF, 32'h0, 0);
         cycle();
      end
      check("conflict_grants", 32'(pat), RrEn ? 32'hA : 32'hF);
      check("conflict_cnt4", 32'(cnt), 32'd4);
      cycle();
      check("sat_cnt", 32'(cnt2), 32'd3);
      idle();
      cycle();

      // Reset asserted in the response cycle: the response is discarded
      set_req(0, 1, 15'h0010, 4'hF, 32'h0, 0);
      cycle();
      reset_ni = 1'b0;
      model_reset();
      idle();
      cycle();
      reset_ni = 1'b1;
      cycle();
      set_req(0, 1, 15'h3, 4'hF, 32'h0, 0);
      set_req(1, 1, 15'h4, 4'hF, 32'h0, 0);
      cycle();
      check("post_reset_winner", 32'(pat[0]), 32'd1);

      // Randomized traffic, including dropped requests and switches
      for (int i = 0; i < 400; i++) begin
         for (int x = 0; x < 2; x++)
            set_req(x, ($urandom_range(0, 3) != 0), 15'($urandom_range(0, 63)),
                    4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 1) == 1);
         cycle();
      end
      idle();
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
